// File: rtl/vga_timing_if.sv
// Raster timing bundle from vga_timing_gen to the pixel pipeline and DAC pins.
// rgb is carried only when VGA_TIMING_TEST_PATTERN_EN is defined.
interface vga_timing_if #(
  parameter int COORD_WIDTH = 11
);
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [COORD_WIDTH-1:0] pixel_x;
  logic [COORD_WIDTH-1:0] pixel_y;
  logic                   line_start;
  logic                   frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0]            rgb;
`endif

  modport master (
    output hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , output rgb
`endif
  );

  modport slave (
    input hsync, vsync, de, pixel_x, pixel_y, line_start, frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , input rgb
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a ce-gated output delay line.
// Optional colour-bar pattern on rgb under macro VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int H_SYNC_POL    = 0,
  parameter int V_SYNC_POL    = 0,
  parameter int PIPE_DELAY    = 0,
  parameter int COORD_WIDTH   = 11
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          pixel_ce,
  vga_timing_if.master  vga
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int HS_START = H_VISIBLE + H_FRONT_PORCH;
  localparam int VS_START = V_VISIBLE + V_FRONT_PORCH;

  localparam logic [COORD_WIDTH-1:0] H_LAST_C   = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST_C   = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_VIS_C    = COORD_WIDTH'(H_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] V_VIS_C    = COORD_WIDTH'(V_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] HS_START_C = COORD_WIDTH'(HS_START);
  localparam logic [COORD_WIDTH-1:0] HS_END_C   = COORD_WIDTH'(HS_START + H_SYNC_WIDTH);
  localparam logic [COORD_WIDTH-1:0] VS_START_C = COORD_WIDTH'(VS_START);
  localparam logic [COORD_WIDTH-1:0] VS_END_C   = COORD_WIDTH'(VS_START + V_SYNC_WIDTH);
  localparam logic                   H_POL_C    = (H_SYNC_POL != 0);
  localparam logic                   V_POL_C    = (V_SYNC_POL != 0);

  typedef struct packed {
    logic                   hsync;
    logic                   vsync;
    logic                   de;
    logic                   line_start;
    logic                   frame_start;
    logic [COORD_WIDTH-1:0] pixel_x;
    logic [COORD_WIDTH-1:0] pixel_y;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0]            rgb;
`endif
  } out_t;

  function automatic out_t idle_value();
    out_t o;
    o       = '0;
    o.hsync = ~H_POL_C;
    o.vsync = ~V_POL_C;
    return o;
  endfunction

  localparam out_t IDLE = idle_value();

  logic [COORD_WIDTH-1:0] h_q, h_d;
  logic [COORD_WIDTH-1:0] v_q, v_d;
  out_t                   dec_d;
  out_t                   pipe_q [0:PIPE_DELAY];

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_ce) begin
      if (h_q == H_LAST_C) begin
        h_d = '0;
        v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

`ifdef VGA_TIMING_TEST_PATTERN_EN
  // Remainder pixels beyond 8*BAR_W fall into the last bar via the clamp.
  localparam int BAR_W = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam logic [COORD_WIDTH-1:0] BAR_W_C = COORD_WIDTH'(BAR_W);
  logic [COORD_WIDTH-1:0] bar_k;
  logic [2:0]             bar_sel;
  always_comb begin
    bar_k   = h_q / BAR_W_C;
    bar_sel = (bar_k > COORD_WIDTH'(7)) ? 3'd7 : bar_k[2:0];
  end
`endif

  always_comb begin
    dec_d             = '0;
    dec_d.de          = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    dec_d.hsync       = ((h_q >= HS_START_C) && (h_q < HS_END_C)) ? H_POL_C : ~H_POL_C;
    dec_d.vsync       = ((v_q >= VS_START_C) && (v_q < VS_END_C)) ? V_POL_C : ~V_POL_C;
    dec_d.line_start  = (h_q == '0);
    dec_d.frame_start = (h_q == '0) && (v_q == '0);
    dec_d.pixel_x     = h_q;
    dec_d.pixel_y     = v_q;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    dec_d.rgb         = dec_d.de ? {{4{bar_sel[2]}}, {4{bar_sel[1]}}, {4{bar_sel[0]}}} : 12'h000;
`endif
  end

  // Counters and every output stage share the same ce gate, so stalls stretch
  // the whole raster without reordering anything.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
      for (int i = 0; i <= PIPE_DELAY; i++) pipe_q[i] <= IDLE;
    end else if (pixel_ce) begin
      h_q       <= h_d;
      v_q       <= v_d;
      pipe_q[0] <= dec_d;
      for (int i = 1; i <= PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vga.hsync       = pipe_q[PIPE_DELAY].hsync;
  assign vga.vsync       = pipe_q[PIPE_DELAY].vsync;
  assign vga.de          = pipe_q[PIPE_DELAY].de;
  assign vga.pixel_x     = pipe_q[PIPE_DELAY].pixel_x;
  assign vga.pixel_y     = pipe_q[PIPE_DELAY].pixel_y;
  assign vga.line_start  = pipe_q[PIPE_DELAY].line_start;
  assign vga.frame_start = pipe_q[PIPE_DELAY].frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
  assign vga.rgb         = pipe_q[PIPE_DELAY].rgb;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small mode at two delays, wide mode)
// checked every cycle against a raster model indexed by ce-cycles since reset.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixel_ce = 1'b0;
  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint n = 0;
  bit     chk_en = 1'b0;

  vga_timing_if #(.COORD_WIDTH(11)) if_a ();
  vga_timing_if #(.COORD_WIDTH(11)) if_b ();
  vga_timing_if #(.COORD_WIDTH(11)) if_c ();

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .PIPE_DELAY(0)
  ) dut_a (.clk_pixel(clk), .reset(reset), .pixel_ce(pixel_ce), .vga(if_a));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(2),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .PIPE_DELAY(3)
  ) dut_b (.clk_pixel(clk), .reset(reset), .pixel_ce(pixel_ce), .vga(if_b));

  vga_timing_gen #(
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .PIPE_DELAY(0)
  ) dut_c (.clk_pixel(clk), .reset(reset), .pixel_ce(pixel_ce), .vga(if_c));

  typedef struct {
    bit       hs, vs, de, ls, fs;
    int       x, y;
    bit [11:0] rgb;
  } exp_t;

  // Output after cnt ce-edges since reset: idle until the delay line fills,
  // then raster position (cnt-1-pd) in row-major order.
  function automatic exp_t model(longint cnt, int hv, int hfp, int hsw, int hbp,
                                 int vv, int vfp, int vsw, int vbp,
                                 int hpol, int vpol, int pd);
    exp_t e;
    int ht, vt, h, v, k;
    longint p;
    bit [2:0] kb;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    e.hs = (hpol == 0); e.vs = (vpol == 0);
    e.de = 0; e.ls = 0; e.fs = 0; e.x = 0; e.y = 0; e.rgb = '0;
    if (cnt > pd) begin
      p = (cnt - 1 - pd) % (ht * vt);
      h = int'(p % ht);
      v = int'(p / ht);
      e.x  = h;
      e.y  = v;
      e.de = (h < hv) && (v < vv);
      e.hs = (h >= hv + hfp && h < hv + hfp + hsw) ? (hpol != 0) : (hpol == 0);
      e.vs = (v >= vv + vfp && v < vv + vfp + vsw) ? (vpol != 0) : (vpol == 0);
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
      if (e.de) begin
        k = h / ((hv / 8 > 0) ? hv / 8 : 1);
        if (k > 7) k = 7;
        kb = k[2:0];
        e.rgb = {kb[2] ? 4'hF : 4'h0, kb[1] ? 4'hF : 4'h0, kb[0] ? 4'hF : 4'h0};
      end
    end
    return e;
  endfunction

  function automatic logic [63:0] pack_exp(exp_t e);
    return 64'({e.hs, e.vs, e.de, e.ls, e.fs, 16'(e.x), 16'(e.y)});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic c, input logic r);
    pixel_ce = c;
    reset    = r;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset) n <= 0;
    else if (pixel_ce) n <= n + 1;
  end

  always @(negedge clk) begin
    exp_t ea, eb, ec;
    if (chk_en) begin
      ea = model(n, 8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 0);
      eb = model(n, 8, 2, 3, 2, 4, 1, 2, 1, 0, 0, 3);
      ec = model(n, 640, 16, 96, 48, 4, 1, 2, 1, 1, 1, 0);
      check("dut_a_outputs", 64'({if_a.hsync, if_a.vsync, if_a.de, if_a.line_start,
            if_a.frame_start, 16'(if_a.pixel_x), 16'(if_a.pixel_y)}), pack_exp(ea));
      check("dut_b_outputs", 64'({if_b.hsync, if_b.vsync, if_b.de, if_b.line_start,
            if_b.frame_start, 16'(if_b.pixel_x), 16'(if_b.pixel_y)}), pack_exp(eb));
      check("dut_c_outputs", 64'({if_c.hsync, if_c.vsync, if_c.de, if_c.line_start,
            if_c.frame_start, 16'(if_c.pixel_x), 16'(if_c.pixel_y)}), pack_exp(ec));
`ifdef VGA_TIMING_TEST_PATTERN_EN
      check("dut_a_rgb", 64'(if_a.rgb), 64'(ea.rgb));
      check("dut_c_rgb", 64'(if_c.rgb), 64'(ec.rgb));
`endif
    end
  end

  initial begin
    int hs_lo, de_hi, ls_cnt, fs_cnt, first_lo_x, c_hs, c_first;
    int last_rise, spacing, fsq;
    logic prev_fs;
    hs_lo = 0; de_hi = 0; ls_cnt = 0; fs_cnt = 0; first_lo_x = -1;
    c_hs = 0; c_first = -1; last_rise = -1; spacing = -1; fsq = 0;

    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk_en = 1'b1;
    check("rst_a_hsync", 64'(if_a.hsync), 64'd1);
    check("rst_a_de", 64'(if_a.de), 64'd0);
    check("rst_c_hsync_idle", 64'(if_c.hsync), 64'd0);

    // Free-running: one full small frame and one full wide line.
    for (int i = 0; i < 7000; i++) begin
      step(1'b1, 1'b0);
      if (i == 0) begin
        check("first_fs", 64'(if_a.frame_start), 64'd1);
        check("first_xy", 64'({16'(if_a.pixel_x), 16'(if_a.pixel_y)}), 64'd0);
      end
      if (i == 3) check("pd3_first_fs", 64'(if_b.frame_start), 64'd1);
      if (i == 120) check("fs_period_120", 64'(if_a.frame_start), 64'd1);
      if (i == 800) check("c_line_period_800", 64'(if_c.line_start), 64'd1);
      if (i < 120) begin
        if (!if_a.hsync) begin
          hs_lo++;
          if (first_lo_x < 0) first_lo_x = int'(if_a.pixel_x);
        end
        if (if_a.de) de_hi++;
        if (if_a.line_start) ls_cnt++;
        if (if_a.frame_start) fs_cnt++;
      end
      if (i < 800 && if_c.hsync) begin
        c_hs++;
        if (c_first < 0) c_first = int'(if_c.pixel_x);
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (i == 0 || i == 79) check("rgb_bar0", 64'(if_c.rgb), 64'h000);
      if (i == 80) check("rgb_bar1", 64'(if_c.rgb), 64'h00F);
      if (i == 560 || i == 639) check("rgb_bar7", 64'(if_c.rgb), 64'hFFF);
      if (i == 640) check("rgb_blank", 64'(if_c.rgb), 64'h000);
`endif
    end
    check("a_hsync_low_cycles", 64'(hs_lo), 64'd24);
    check("a_first_hsync_x", 64'(first_lo_x), 64'd10);
    check("a_de_cycles", 64'(de_hi), 64'd32);
    check("a_line_starts", 64'(ls_cnt), 64'd8);
    check("a_frame_starts", 64'(fs_cnt), 64'd1);
    check("c_hsync_high_cycles", 64'(c_hs), 64'd96);
    check("c_first_hsync_x", 64'(c_first), 64'd656);

    // ce toggling 1,0,1,0: frame period doubles, one qualified strobe per frame.
    prev_fs = if_a.frame_start;
    for (int j = 0; j < 480; j++) begin
      step((j % 2) == 0, 1'b0);
      if ((j % 2) == 0 && if_a.frame_start) fsq++;
      if (if_a.frame_start && !prev_fs) begin
        if (last_rise >= 0 && spacing < 0) spacing = j - last_rise;
        last_rise = j;
      end
      prev_fs = if_a.frame_start;
    end
    check("toggle_fs_spacing", 64'(spacing), 64'd240);
    check("toggle_fs_count", 64'(fsq), 64'd2);

    for (int j = 0; j < 2000; j++) step(1'($urandom_range(0, 1)), 1'b0);

    // Reset while the counters sit at h=6, v=2.
    for (int k = 0; k < 200 && (n % 120) != 36; k++) step(1'b1, 1'b0);
    check("reach_h6_v2", 64'(if_a.pixel_x), 64'd5);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1);
      check("mid_rst_sync_de_x", 64'({if_a.hsync, if_a.vsync, if_a.de, 16'(if_a.pixel_x)}),
            64'({1'b1, 1'b1, 1'b0, 16'd0}));
    end
    step(1'b1, 1'b0);
    check("post_rst_fs", 64'(if_a.frame_start), 64'd1);
    check("post_rst_xy", 64'({16'(if_a.pixel_x), 16'(if_a.pixel_y)}), 64'd0);

    for (int j = 0; j < 4000; j++)
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the pixel-clock domain. Sweeps a horizontal/vertical counter pair over a configurable mode, and produces registered sync, data-enable, pixel coordinates and line/frame strobes for the pixel pipeline and DAC pins. The sync, enable and coordinate outputs can be delayed by a fixed number of stages so they stay aligned with downstream pixel-generation latency. It replaces the fixed 640x480 counters and drives the board's `vga_horizontal_sync`/`vga_vertical_sync` pins.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT_PORCH`, 16, pixels after visible area
- `H_SYNC_WIDTH`, 96, hsync pulse width in pixels
- `H_BACK_PORCH`, 48, pixels after sync
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT_PORCH`, 10, lines after visible area
- `V_SYNC_WIDTH`, 2, vsync pulse width in lines
- `V_BACK_PORCH`, 33, lines after sync
- `H_SYNC_POL`, 0, active level of hsync (0 = active-low)
- `V_SYNC_POL`, 0, active level of vsync
- `PIPE_DELAY`, 0, extra register stages on all outputs (0..8)
- `COORD_WIDTH`, 11, width of the counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- `clk_pixel` in 1: pixel clock. One clock; every output is registered on its rising edge.
- `reset` in 1: reset is synchronous and active-high.
- `pixel_ce` in 1: counter advance enable. When low, the counters hold and the output pipeline holds.
- `hsync` out 1: horizontal sync, polarity per `H_SYNC_POL`
- `vsync` out 1: vertical sync, polarity per `V_SYNC_POL`
- `de` out 1: high while inside the visible area
- `pixel_x` out COORD_WIDTH: horizontal position
- `pixel_y` out COORD_WIDTH: vertical position
- `line_start` out 1: one-cycle strobe at position h=0
- `frame_start` out 1: one-cycle strobe at position h=0, v=0
- `rgb` out 12: {r[3:0],g[3:0],b[3:0]}. Only present under `VGA_TIMING_TEST_PATTERN_EN`.

## Operation
Derived totals:
- H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH
- V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH

Line order is: visible, front porch, sync, back porch.

Counter behaviour:
- The `h` counter increments on each `pixel_ce` cycle and wraps from H_TOTAL-1 to 0.
- The `v` counter increments only on that h wrap, and wraps from V_TOTAL-1 to 0.
- Both counters hold when `pixel_ce`=0.

Combinational decode of the counter state:
- de = (h < H_VISIBLE) && (v < V_VISIBLE)
- hsync is active when H_VISIBLE+H_FRONT_PORCH <= h < H_VISIBLE+H_FRONT_PORCH+H_SYNC_WIDTH. The upper bound is exclusive, giving exactly H_SYNC_WIDTH cycles.
- vsync is active over the same half-open range on v, computed the same way from the vertical parameters.
- line_start = (h==0); frame_start = (h==0 && v==0)
- pixel_x = h and pixel_y = v, so coordinates are valid even outside de.

Output stage:
- The decode is registered once (stage 0), then passes through PIPE_DELAY further stages.
- Each stage advances only when `pixel_ce`=1.
- Strobes are qualified with `pixel_ce`, so each one is high for exactly one `pixel_ce`-qualified cycle.

Reset:
- h=0 and v=0.
- Every pipeline stage loads its idle value: hsync=!H_SYNC_POL, vsync=!V_SYNC_POL, de=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, rgb=0.
- Reset applied mid-line or mid-frame behaves identically. The first frame_start appears on the first `pixel_ce` cycle after reset release, reflecting position (0,0).

## Timing
- Latency from counter state to outputs is 1+PIPE_DELAY `pixel_ce` cycles. All outputs are mutually aligned at every PIPE_DELAY.
- Period: line_start every H_TOTAL ce-cycles; frame_start every H_TOTAL*V_TOTAL ce-cycles.
- Wrap boundary: on the cycle where h=H_TOTAL-1 and v=V_TOTAL-1, both counters wrap together. The next output state is (0,0) with frame_start=1 and line_start=1.
- vsync edges coincide with h=0 of the first and last+1 sync line, not mid-line.
- `pixel_ce` low for N cycles stretches all outputs by N cycles, with no state lost.

## Configuration
Macro `VGA_TIMING_TEST_PATTERN_EN`:
- **Defined:**
  - `rgb` exists and is registered in stage 0 alongside the other outputs.
  - While de=1, the screen shows eight vertical colour bars of width H_VISIBLE/8 (integer division; any remainder pixels take the last bar). Bar index k = pixel_x/(H_VISIBLE/8), clamped to 7.
  - Each colour channel is 4'hF or 4'h0: r is set by bit2 of k, g by bit1, b by bit0.
  - While de=0, rgb=12'h000.
- **Undefined:** `rgb` is absent from the port list and no pattern logic is synthesised.

## Test plan
- Small mode (H 8/2/3/2, V 4/1/2/1, H_TOTAL=15, V_TOTAL=8, PIPE_DELAY=0), ce=1 -> line_start every 15 cycles; hsync low exactly at h=10..12; de high 8 cycles per line on lines 0..3 only; frame_start every 120 cycles.
- Same mode, PIPE_DELAY=3 -> all output waveforms identical to the PIPE_DELAY=0 run, shifted by exactly 3 cycles.
- `pixel_ce` toggling 1,0,1,0 -> frame_start period becomes 240 clocks; no duplicate strobes; outputs hold on ce=0 cycles.
- Reset asserted at h=6, v=2 for 2 cycles -> during reset hsync=1, vsync=1, de=0, pixel_x=0; after release the first ce cycle gives frame_start=1 with pixel_x=0, pixel_y=0.
- Default 640x480, H_SYNC_POL=1 -> 800 clocks per line, 525 lines; hsync high for exactly 96 clocks starting at h=656; vsync high for exactly 2 lines starting at v=490.
- With `VGA_TIMING_TEST_PATTERN_EN`, default mode -> rgb=12'h000 at x=0..79, 12'h00F at x=80, 12'hFFF at x=560..639, 12'h000 at x=640.
